// File: rtl/alu_src_b_sequencer.sv
// -----------------------------------------------------------------------------
// alu_src_b_sequencer
//
// Purpose
//   Moore-style instruction sequencer that steers the ALU operand-B mux and
//   frames each instruction into execute / write-back steps. One instruction
//   is in flight at a time. Most opcodes take one execute step. NEG (opcode
//   13) takes two: XOR with all-ones, then add one. HALT (opcode 15) parks
//   the sequencer until reset.
//
// Optional feature (compile-time macro)
//   ILLEGAL_TRAP_EN - when defined, opcode 14 parks the sequencer in HALT and
//                     raises the sticky Trap flag. When undefined, opcode 14
//                     retires as a NOP and Trap is tied low.
//
// Ports
//   CLK          in   system clock; all state changes on the rising edge
//   ResetN       in   synchronous active-low reset
//   InstValid    in   instruction offered this cycle
//   Inst[8:0]    in   opcode Inst[8:5], immediate Inst[2:0], shamt Inst[1:0]
//   InstReady    out  sequencer can accept (IDLE only)
//   ALUSrcBCtrl  out  operand-B select code 0..12 (3 = constant zero)
//   ExecValid    out  ALU executes a step this cycle
//   ALUXor       out  ALU performs XOR instead of ADD this step
//   RegWrite     out  write the ALU result to the destination register
//   Done         out  one-cycle retirement pulse
//   Halted       out  sticky halt indication
//   Trap         out  sticky illegal-opcode indication
// -----------------------------------------------------------------------------
module alu_src_b_sequencer (
  input  logic       CLK,
  input  logic       ResetN,
  input  logic       InstValid,
  input  logic [8:0] Inst,
  output logic       InstReady,
  output logic [3:0] ALUSrcBCtrl,
  output logic       ExecValid,
  output logic       ALUXor,
  output logic       RegWrite,
  output logic       Done,
  output logic       Halted,
  output logic       Trap
);

  // FSM encoding
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StExec1 = 3'd1;
  localparam logic [2:0] StExec2 = 3'd2;
  localparam logic [2:0] StWb    = 3'd3;
  localparam logic [2:0] StHalt  = 3'd4;

  // Opcodes with special sequencing
  localparam logic [3:0] OpShift   = 4'd1;
  localparam logic [3:0] OpNeg     = 4'd13;
  localparam logic [3:0] OpIllegal = 4'd14;
  localparam logic [3:0] OpHalt    = 4'd15;

  // Operand-B select codes used outside the plain opcode mapping
  localparam logic [3:0] SrcZero   = 4'd3;  // constant zero, idle value
  localparam logic [3:0] SrcAllOne = 4'd8;  // NEG step 1: XOR with all-ones
  localparam logic [3:0] SrcOne    = 4'd9;  // NEG step 2: add one

  logic [2:0] stateQ, stateD;
  logic [8:0] instQ, instD;
  logic       haltEntryQ, haltEntryD;

  // Fields of the incoming instruction (used only for the accept decision)
  logic [3:0] inOpcode;
  logic [1:0] inShamt;
  assign inOpcode = Inst[8:5];
  assign inShamt  = Inst[1:0];

  // Fields of the latched instruction (drive all outputs)
  logic [3:0] opcodeQ;
  logic [1:0] shamtQ;
  assign opcodeQ = instQ[8:5];
  assign shamtQ  = instQ[1:0];

  // The immediate and spare bits are carried for the datapath, not decoded here
  logic unusedInstBits;
  assign unusedInstBits = ^instQ[4:2];

  // Latched instruction retires without writing the register file
  logic instIsNopQ;
  always_comb begin
    instIsNopQ = (opcodeQ == OpShift) && (shamtQ == 2'b00);
`ifndef ILLEGAL_TRAP_EN
    if (opcodeQ == OpIllegal) instIsNopQ = 1'b1;
`endif
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    stateD     = stateQ;
    instD      = instQ;
    haltEntryD = 1'b0;

    case (stateQ)
      StIdle: begin
        if (InstValid) begin
          instD = Inst;
          case (inOpcode)
            OpHalt: begin
              stateD     = StHalt;
              haltEntryD = 1'b1;  // Done pulses only on the first HALT cycle
            end
            OpIllegal: begin
`ifdef ILLEGAL_TRAP_EN
              stateD = StHalt;    // trap: no retirement pulse
`else
              stateD = StWb;      // retire as NOP
`endif
            end
            OpShift: begin
              // Zero shift amount has no effect; skip the execute step
              stateD = (inShamt == 2'b00) ? StWb : StExec1;
            end
            default: stateD = StExec1;
          endcase
        end
      end
      StExec1: stateD = (opcodeQ == OpNeg) ? StExec2 : StWb;
      StExec2: stateD = StWb;
      StWb:    stateD = StIdle;
      StHalt:  stateD = StHalt;
      default: stateD = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers, synchronous active-low reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!ResetN) begin
      stateQ     <= StIdle;
      instQ      <= 9'd0;
      haltEntryQ <= 1'b0;
    end else begin
      stateQ     <= stateD;
      instQ      <= instD;
      haltEntryQ <= haltEntryD;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs: registered state and latched instruction only
  // ---------------------------------------------------------------------------
  always_comb begin
    InstReady   = 1'b0;
    ALUSrcBCtrl = SrcZero;
    ExecValid   = 1'b0;
    ALUXor      = 1'b0;
    RegWrite    = 1'b0;
    Done        = 1'b0;
    Halted      = 1'b0;

    case (stateQ)
      StIdle: InstReady = 1'b1;
      StExec1: begin
        ExecValid = 1'b1;
        if (opcodeQ == OpNeg) begin
          ALUSrcBCtrl = SrcAllOne;
          ALUXor      = 1'b1;
        end else begin
          // Opcodes 0..12 select the operand-B source of the same number
          ALUSrcBCtrl = opcodeQ;
        end
      end
      StExec2: begin
        ExecValid   = 1'b1;
        ALUSrcBCtrl = SrcOne;
      end
      StWb: begin
        RegWrite = !instIsNopQ;
        Done     = 1'b1;
      end
      StHalt: begin
        Halted = 1'b1;
        Done   = haltEntryQ;
      end
      default: ;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  // Only an illegal opcode can park in HALT with opcode 14 latched
  assign Trap = (stateQ == StHalt) && (opcodeQ == OpIllegal);
`else
  assign Trap = 1'b0;
`endif

endmodule

// File: doc/alu_src_b_sequencer.md
ALU_SRC_B_SEQUENCER -- requirements
Module: AluSrcBSequencer

Interface
REQ-001 SHALL have CLK, input, 1, single system clock; all state changes on rising edge.
REQ-002 SHALL have ResetN, input, 1, reset sampled on the rising edge of CLK: synchronous, active-low.
REQ-003 SHALL have InstValid, input, 1, instruction offered this cycle.
REQ-004 SHALL have Inst, input, 9, instruction: opcode Inst[8:5], immediate Inst[2:0], shamt Inst[1:0].
REQ-005 SHALL have InstReady, output, 1, sequencer can accept; instruction accepted when InstValid && InstReady.
REQ-006 SHALL have ALUSrcBCtrl, output, 4, ALU operand-B select code (0..12), driven to the operand-B mux.
REQ-007 SHALL have ExecValid, output, 1, ALU is executing a step this cycle.
REQ-008 SHALL have ALUXor, output, 1, ALU performs XOR instead of ADD this step.
REQ-009 SHALL have RegWrite, output, 1, write ALU result to destination register this cycle.
REQ-010 SHALL have Done, output, 1, one-cycle pulse at instruction retirement.
REQ-011 SHALL have Halted, output, 1, sticky halt indication.
REQ-012 SHALL have Trap, output, 1, sticky illegal-opcode indication (see Configuration).

Function
REQ-013 SHALL implement Moore FSM states IDLE, EXEC1, EXEC2, WB, HALT; all outputs decoded from registered state and latched instruction only.
REQ-014 SHALL assert InstReady only in IDLE; Inst SHALL be latched on acceptance and held until return to IDLE.
REQ-015 Opcode mapping for EXEC1 ALUSrcBCtrl: 0 -> 0 (register B); 1 -> 1 (shift amount); 2 -> 2 (immediate); 3..12 -> code equal to opcode.
REQ-016 Opcodes 0..12 SHALL sequence IDLE -> EXEC1 -> WB -> IDLE: accept at cycle N, ExecValid at N+1, RegWrite and Done at N+2, InstReady at N+3.
REQ-017 Opcode 1 with shamt 00 SHALL be a NOP: IDLE -> WB with RegWrite=0, Done=1 at N+1.
REQ-018 Opcode 13 (NEG) SHALL sequence IDLE -> EXEC1 (ALUSrcBCtrl=8, ALUXor=1) -> EXEC2 (ALUSrcBCtrl=9, ALUXor=0) -> WB -> IDLE; RegWrite/Done at N+3.
REQ-019 Opcode 15 (HALT) SHALL go IDLE -> HALT; Done pulses on entry cycle; Halted=1, InstReady=0 in HALT until reset.
REQ-020 Opcode 14 SHALL be illegal; handling per REQ-027/REQ-028.
REQ-021 Outside EXEC1/EXEC2, ALUSrcBCtrl SHALL be 3 (constant zero) and ExecValid, ALUXor SHALL be 0.
REQ-022 RegWrite and Done SHALL be asserted only in WB (except REQ-019 Done); never both Done and InstReady in the same cycle.
REQ-023 InstValid while not in IDLE SHALL be ignored; Inst changes while busy SHALL not affect outputs.

Reset
REQ-024 ResetN=0 at a rising edge SHALL force IDLE and clear latched instruction, Halted, Trap, regardless of current state (including mid-EXEC2 and HALT).
REQ-025 During and after reset cycle outputs SHALL be: InstReady=1, ALUSrcBCtrl=3, ExecValid=0, ALUXor=0, RegWrite=0, Done=0, Halted=0, Trap=0.
REQ-026 ResetN=0 SHALL take priority over an InstValid presented in the same cycle; no instruction is accepted.

Configuration
REQ-027 With ILLEGAL_TRAP_EN defined, opcode 14 SHALL go IDLE -> HALT with Trap=1 and Halted=1, no Done pulse, until reset.
REQ-028 Without ILLEGAL_TRAP_EN, opcode 14 SHALL execute as NOP (IDLE -> WB, RegWrite=0, Done=1) and Trap SHALL be tied 0.

Verification
REQ-029 Reset, then Inst=9'b000_0_00000 (opcode 0) valid at N -> ExecValid=1, ALUSrcBCtrl=0 at N+1; RegWrite=Done=1 at N+2; InstReady=1 at N+3.
REQ-030 Opcode 1 shamt 11 -> ALUSrcBCtrl=1 at N+1, RegWrite at N+2; opcode 1 shamt 00 -> Done=1, RegWrite=0 at N+1.
REQ-031 Opcode 13 -> N+1: code 8, ALUXor=1; N+2: code 9, ALUXor=0; N+3: RegWrite=Done=1.
REQ-032 Opcode 15 -> Done at N+1, Halted=1, InstReady=0 held 10 cycles with InstValid=1; ResetN=0 one cycle -> IDLE, Halted=0.
REQ-033 Opcode 14 -> with ILLEGAL_TRAP_EN: Trap=Halted=1, no Done; without: Done=1, RegWrite=0 at N+1, Trap=0.
REQ-034 Reset asserted in EXEC2 of opcode 13 -> next cycle IDLE outputs per REQ-025, no RegWrite or Done emitted.
